// File: rtl/rr_arb4_reg32.sv
// rr_arb4_reg32: four-source round-robin arbiter with a registered output stage.
//
// Each cycle the arbiter picks one of four producers (in1..in4) and captures the
// winner's word into a single output register. The output register has a valid/ready
// handshake toward the consumer. The 2-bit grant (sel) uses the shared 4-to-1 mux
// encoding: 00=in1, 01=in2, 10=in3, 11=in4.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in1..in4   source data words (WIDTH bits each)
//   valid      per-source valid, valid[0]=in1 .. valid[3]=in4
//   ready      per-source accept, at most one bit high
//   sel        current grant / mux select
//   out        registered winning word
//   out_valid  out holds an undelivered word
//   out_src    select code of the source that produced out
//   out_ready  consumer accepts out this cycle
//
// Optional feature, enabled with macro RR_ARB_CNT_EN:
//   cnt_clr    synchronous clear of all transfer counters (wins over increment)
//   cnt        four saturating 8-bit transfer counters, cnt[7:0]=in1 .. cnt[31:24]=in4
module rr_arb4_reg32 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [WIDTH-1:0] in4,
    input  logic [3:0]       valid,
    output logic [3:0]       ready,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic [1:0]       out_src,
`ifdef RR_ARB_CNT_EN
    input  logic             cnt_clr,
    output logic [31:0]      cnt,
`endif
    input  logic             out_ready
);

    logic [WIDTH-1:0] out_q;
    logic             out_valid_q;
    logic [1:0]       out_src_q;
    logic [1:0]       lg_q;

    logic [1:0]       grant;
    logic             grant_valid;
    logic [1:0]       idx;
    logic             load;
    logic             xfer;
    logic [WIDTH-1:0] word_sel;

    // Scan lg+1, lg+2, lg+3, lg (mod 4). The 2-bit add wraps naturally.
    always_comb begin
        grant_valid = 1'b0;
        grant       = lg_q;
        idx         = lg_q;
        for (int k = 1; k <= 4; k++) begin
            idx = lg_q + 2'(k);
            if (!grant_valid && valid[idx]) begin
                grant_valid = 1'b1;
                grant       = idx;
            end
        end
    end

    assign load = !out_valid_q || out_ready;
    assign xfer = grant_valid && load && !reset;

    always_comb begin
        ready = 4'b0000;
        if (xfer) begin
            ready = 4'b0001 << grant;
        end
    end

    // The pointer is already 11 during reset, but sel is forced to 00 explicitly.
    assign sel = reset ? 2'b00 : grant;

    always_comb begin
        case (grant)
            2'b00:   word_sel = in1;
            2'b01:   word_sel = in2;
            2'b10:   word_sel = in3;
            default: word_sel = in4;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            out_src_q   <= 2'b00;
            lg_q        <= 2'b11;
        end else if (xfer) begin
            // Covers both a plain fill and a same-edge drain+refill.
            out_q       <= word_sel;
            out_src_q   <= grant;
            out_valid_q <= 1'b1;
            lg_q        <= grant;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign out_src   = out_src_q;

`ifdef RR_ARB_CNT_EN
    logic [3:0][7:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (cnt_clr) begin
            cnt_q <= '0;
        end else if (xfer && (cnt_q[grant] != 8'hFF)) begin
            cnt_q[grant] <= cnt_q[grant] + 8'd1;
        end
    end

    assign cnt = cnt_q;
`endif

endmodule

// File: tb/tb_rr_arb4_reg32.sv
module tb_rr_arb4_reg32;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [3:0][31:0] d;
    logic [3:0]       valid = 4'b0000;
    logic [3:0]       ready;
    logic [1:0]       sel;
    logic [31:0]      out;
    logic             out_valid;
    logic [1:0]       out_src;
    logic             out_ready = 1'b0;
`ifdef RR_ARB_CNT_EN
    logic             cnt_clr = 1'b0;
    logic [31:0]      cnt;
`endif

    always #5 clk = ~clk;

    rr_arb4_reg32 #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in1       (d[0]),
        .in2       (d[1]),
        .in3       (d[2]),
        .in4       (d[3]),
        .valid     (valid),
        .ready     (ready),
        .sel       (sel),
        .out       (out),
        .out_valid (out_valid),
        .out_src   (out_src),
`ifdef RR_ARB_CNT_EN
        .cnt_clr   (cnt_clr),
        .cnt       (cnt),
`endif
        .out_ready (out_ready)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Scoreboard entry: {source code, word}
    logic [33:0] sb[$];

    // Reference model state
    int m_lg;
    bit m_ov;
    int m_cnt[4];
    bit last_xfer;
    int last_win;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_lg = 3;
        m_ov = 0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        sb.delete();
    endtask

    // One cycle: drive after the edge, check combinational outputs at negedge,
    // and advance the model to the following rising edge.
    task automatic step(input logic [3:0] v, input logic ordy, input logic clr,
                        input logic [3:0][31:0] nd);
        int  win;
        bit  load;
        logic [3:0] exp_ready;
        @(posedge clk);
        #1;
        valid     = v;
        out_ready = ordy;
        d         = nd;
`ifdef RR_ARB_CNT_EN
        cnt_clr   = clr;
`endif
        @(negedge clk);
        win = -1;
        for (int k = 1; k <= 4; k++) begin
            if (win < 0 && v[(m_lg + k) % 4]) win = (m_lg + k) % 4;
        end
        load      = !m_ov || ordy;
        exp_ready = (win >= 0 && load) ? 4'(1 << win) : 4'b0000;
        chk("ready", 64'(ready), 64'(exp_ready));
        chk("sel", 64'(sel), 64'((win >= 0) ? win : m_lg));
        chk("out_valid", 64'(out_valid), 64'(m_ov));
`ifdef RR_ARB_CNT_EN
        chk("cnt", 64'(cnt), 64'({m_cnt[3][7:0], m_cnt[2][7:0], m_cnt[1][7:0], m_cnt[0][7:0]}));
`endif
        last_xfer = (exp_ready != 4'b0000);
        last_win  = win;
        if (last_xfer) begin
            sb.push_back({2'(win), nd[win]});
            m_lg = win;
            m_ov = 1;
        end else if (ordy) begin
            m_ov = 0;
        end
        if (clr) begin
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        end else if (last_xfer && m_cnt[win] < 255) begin
            m_cnt[win]++;
        end
    endtask

    // Monitor: whatever the DUT presents must match the oldest expected word.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_empty: got out=%0h with nothing expected at %0t", out, $time);
            end else begin
                chk("out", 64'(out), 64'(sb[0][31:0]));
                chk("out_src", 64'(out_src), 64'(sb[0][33:32]));
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        logic [3:0][31:0] nd;
        logic [3:0]       pend;
        nd = '0;
        d  = '0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // First grant after reset is in1
        for (int i = 0; i < 4; i++) nd[i] = 32'(i + 1);
        step(4'b1111, 1'b1, 1'b0, nd);

        // Single source in3
        nd[2] = 32'h12345678;
        step(4'b0100, 1'b1, 1'b0, nd);
        step(4'b0000, 1'b1, 1'b0, nd);

        // Round-robin with all sources valid
        for (int i = 0; i < 4; i++) nd[i] = 32'(i + 1);
        repeat (9) step(4'b1111, 1'b1, 1'b0, nd);

        // Backpressure for 5 cycles, then release
        repeat (5) step(4'b1111, 1'b0, 1'b0, nd);
        repeat (4) step(4'b1111, 1'b1, 1'b0, nd);

        // Drain-only, then a lone in1 request
        step(4'b0000, 1'b1, 1'b0, nd);
        step(4'b0000, 1'b1, 1'b0, nd);
        step(4'b0001, 1'b1, 1'b0, nd);

        // Async reset mid-stall with DEADBEEF held
        nd[0] = 32'hDEADBEEF;
        step(4'b0001, 1'b0, 1'b0, nd);
        step(4'b0001, 1'b0, 1'b0, nd);
        step(4'b1111, 1'b0, 1'b0, nd);
        #3;
        valid     = 4'b0000;
        out_ready = 1'b0;
        reset     = 1'b1;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out", 64'(out), 64'(0));
        chk("rst_out_src", 64'(out_src), 64'(0));
        chk("rst_ready", 64'(ready), 64'(0));
        chk("rst_sel", 64'(sel), 64'(0));
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        step(4'b1111, 1'b1, 1'b0, nd);
        step(4'b0000, 1'b1, 1'b0, nd);

        // Randomized traffic; a source keeps valid and data until accepted
        pend = 4'b0000;
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    nd[i]   = $urandom;
                end
            end
            step(pend, 1'($urandom_range(0, 3) != 0), 1'b0, nd);
            if (last_xfer) pend[last_win] = 1'b0;
        end
        repeat (2) step(pend, 1'b1, 1'b0, nd);
        pend = 4'b0000;
        repeat (2) step(4'b0000, 1'b1, 1'b0, nd);

`ifdef RR_ARB_CNT_EN
        // Saturate the in2 counter, then clear coinciding with a transfer
        step(4'b0000, 1'b1, 1'b1, nd);
        repeat (300) step(4'b0010, 1'b1, 1'b0, nd);
        step(4'b0010, 1'b1, 1'b0, nd);
        chk("cnt_sat_in2", 64'(cnt), 64'(32'h0000_FF00));
        step(4'b0010, 1'b1, 1'b1, nd);
        step(4'b0000, 1'b1, 1'b0, nd);
        chk("cnt_clr", 64'(cnt), 64'(0));
`endif

        step(4'b0000, 1'b1, 1'b0, nd);
        chk("sb_drained", 64'(sb.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
